fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Sequences audio samples into the FFT core one frame at a time.
- Each frame, it chooses the sample source: FIR output in playback mode, raw AC97 audio in record mode.
- Mode changes are applied only at frame boundaries, so no FFT frame ever mixes the two sources.
- Sits between the AC97/FIR sample path and the FFT core; replaces the free-running combinational source select.

Parameters:
- LOG_N, 10, log2 of FFT frame length (N = 2**LOG_N samples per frame).
- PLAYBACK, 2'd1, mode_req encoding that selects from_fir.
- RECORD, 2'd0, mode_req encoding that selects from_ac97.
- TIMEOUT_CYCLES, 65535, WAIT_DONE watchdog limit in clock cycles (used only with FFT_WATCHDOG_EN).

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- ready  input  1  one-cycle sample strobe from the AC97 interface.
- from_fir  input  12  signed FIR output sample.
- from_ac97  input  12  signed raw AC97 sample.
- mode_req  input  2  requested mode (RECORD or PLAYBACK; other codes ignored).
- fft_rfd  input  1  FFT core ready-for-data.
- fft_done  input  1  one-cycle pulse: FFT core finished the frame.
- fft_start  output  1  one-cycle frame start pulse to the FFT core.
- fft_we  output  1  one-cycle sample-valid to the FFT core.
- to_fft  output  12  sample to the FFT core.
- sample_index  output  LOG_N  index of the sample currently presented on to_fft.
- active_mode  output  2  mode latched for the current frame.
- overrun  output  1  one-cycle pulse when a sample is dropped.
- drop_count  output  8  dropped-sample counter; saturates at 255; cleared only by reset.
- timeout  output  1  one-cycle pulse on watchdog expiry (tied 0 without FFT_WATCHDOG_EN).

Behaviour:
- Reset values (asynchronous): state IDLE; fft_start, fft_we, overrun, timeout = 0; to_fft = 0; sample_index = 0; active_mode = RECORD; drop_count = 0.
- States: IDLE -> START -> FILL -> WAIT_DONE -> IDLE.
- IDLE (exactly 1 cycle):
  - If mode_req is RECORD or PLAYBACK, latch it into active_mode; any other code keeps the previous value.
  - Clear the internal write counter.
  - Assert fft_start for this single cycle (registered, visible the next cycle); go to START.
- START: remain until fft_rfd = 1, then go to FILL. A ready strobe in START is dropped.
- FILL, on a ready strobe with fft_rfd = 1:
  - Register the selected source (from_fir if active_mode = PLAYBACK, else from_ac97) into to_fft.
  - Register the write counter into sample_index.
  - Pulse fft_we; all three appear exactly 1 cycle after the strobe (latency 1).
  - Increment the write counter.
  - After the write of index N-1, go to WAIT_DONE; the counter wraps to 0.
- FILL, on a ready strobe with fft_rfd = 0: sample dropped; fft_we stays 0; the write counter does not advance.
- WAIT_DONE: every ready strobe is dropped; fft_done = 1 returns to IDLE on the next cycle.
- Drop handling: every dropped sample pulses overrun 1 cycle after the strobe and increments drop_count; at 255 the counter holds.
- Same-cycle ready and fft_done in WAIT_DONE: the sample is dropped; the state still goes to IDLE.
- mode_req changes outside IDLE have no effect until the next IDLE.
- fft_done outside WAIT_DONE is ignored.
- to_fft and sample_index hold their last values between writes; fft_we is never high for 2 consecutive cycles.
- Samples are 12-bit two's complement, passed through unmodified; no arithmetic is performed on them.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is abandoned; after release, a new frame starts with fft_start.

Optional Feature:
- Macro: FFT_WATCHDOG_EN.
- Defined:
  - A 16-bit cycle counter clears on entry to WAIT_DONE and counts each cycle spent there.
  - If it reaches TIMEOUT_CYCLES without fft_done, pulse timeout for 1 cycle and go to IDLE.
  - If fft_done arrives on the same cycle, fft_done wins and timeout stays 0.
- Undefined: no counter; timeout is tied to 0; WAIT_DONE waits indefinitely for fft_done.

Test Plan:
- LOG_N=3, mode_req=RECORD, fft_rfd=1, 8 ready strobes with from_ac97 = 0x001..0x008 -> one fft_start; 8 fft_we pulses, each 1 cycle after its strobe; to_fft = 0x001..0x008; sample_index = 0..7; state reaches WAIT_DONE.
- Mid-FILL, mode_req switched to PLAYBACK, from_fir=0x7FF -> current frame continues using from_ac97; after fft_done, the next frame's samples equal 0x7FF and active_mode = 1.
- fft_rfd=0 for 3 strobes in FILL -> no fft_we; 3 overrun pulses; drop_count = 3; sample_index resumes at the same value once fft_rfd returns to 1.
- 300 strobes during WAIT_DONE -> drop_count saturates at 255; then fft_done -> IDLE with fft_start 1 cycle later.
- reset asserted at sample 5 of a frame -> all outputs return to reset values asynchronously; after release, fft_start, then sample_index restarts at 0.
- With FFT_WATCHDOG_EN and TIMEOUT_CYCLES=20, no fft_done -> timeout pulses exactly 20 cycles after WAIT_DONE entry, followed by a new fft_start; without the macro, timeout stays 0 indefinitely.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//
// Feeds audio samples into the FFT core one frame (N = 2**LOG_N samples) at a
// time. The sample source is chosen once per frame: FIR output in playback
// mode, raw AC97 audio in record mode. Because the mode is only sampled in
// IDLE, no FFT frame can ever contain a mix of both sources.
//
// Frame flow: IDLE -> START -> FILL -> WAIT_DONE -> IDLE
//
// Optional feature macro: FFT_WATCHDOG_EN
//   When defined, a 16-bit watchdog counts the cycles spent in WAIT_DONE.
//   If TIMEOUT_CYCLES pass without fft_done, it pulses timeout and returns
//   to IDLE. When undefined, timeout is tied low and WAIT_DONE waits forever.
//
// Ports:
//   clock        in   system clock (only clock)
//   reset        in   asynchronous active-high reset
//   ready        in   one-cycle sample strobe from the AC97 interface
//   from_fir     in   12-bit signed FIR output sample
//   from_ac97    in   12-bit signed raw AC97 sample
//   mode_req     in   requested mode (RECORD / PLAYBACK, others ignored)
//   fft_rfd      in   FFT core ready-for-data
//   fft_done     in   one-cycle pulse, FFT core finished the frame
//   fft_start    out  one-cycle frame start pulse
//   fft_we       out  one-cycle sample-valid
//   to_fft       out  sample presented to the FFT core
//   sample_index out  index of the sample on to_fft
//   active_mode  out  mode latched for the current frame
//   overrun      out  one-cycle pulse when a sample is dropped
//   drop_count   out  saturating dropped-sample counter
//   timeout      out  one-cycle watchdog expiry pulse
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
   parameter int         LOG_N          = 10,
   parameter logic [1:0] PLAYBACK       = 2'd1,
   parameter logic [1:0] RECORD         = 2'd0,
   parameter int         TIMEOUT_CYCLES = 65535
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ready,
   input  logic [11:0]      from_fir,
   input  logic [11:0]      from_ac97,
   input  logic [1:0]       mode_req,
   input  logic             fft_rfd,
   input  logic             fft_done,
   output logic             fft_start,
   output logic             fft_we,
   output logic [11:0]      to_fft,
   output logic [LOG_N-1:0] sample_index,
   output logic [1:0]       active_mode,
   output logic             overrun,
   output logic [7:0]       drop_count,
   output logic             timeout
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START     = 2'd1;
   localparam logic [1:0] FILL      = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   localparam logic [LOG_N-1:0] LAST_INDEX = {LOG_N{1'b1}};

   logic [1:0]       state;
   logic [LOG_N-1:0] wr_cnt;
   logic             sample_write;
   logic             sample_drop;
   logic             wd_expire;

   // A strobe is only accepted while filling with the core ready. The
   // !fft_we term guarantees write-enable can never be high two cycles in a
   // row even if ready were held high. Anything else is a dropped sample.
   assign sample_write = ready && (state == FILL) && fft_rfd && !fft_we;
   assign sample_drop  = ready && !sample_write;

`ifdef FFT_WATCHDOG_EN
   logic [15:0] wd_cnt;

   // The watchdog fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_DONE.
   assign wd_expire = (state == WAIT_DONE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: held at zero outside WAIT_DONE so that it starts
   // from zero on every entry. A coincident fft_done suppresses the timeout
   // pulse since the frame actually completed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_cnt  <= 16'd0;
         timeout <= 1'b0;
      end else begin
         timeout <= wd_expire && !fft_done;
         if (state != WAIT_DONE) begin
            wd_cnt <= 16'd0;
         end else begin
            wd_cnt <= wd_cnt + 16'd1;
         end
      end
   end
`else
   logic [15:0] wd_limit_unused;

   assign wd_limit_unused = 16'(TIMEOUT_CYCLES);
   assign wd_expire       = 1'b0;
   assign timeout         = 1'b0;
`endif

   // Main frame sequencer. Pulses (fft_start, fft_we, overrun) default low
   // every cycle so each is exactly one cycle wide. to_fft and sample_index
   // are only written on an accepted sample, so they hold between writes.
   // The write counter naturally wraps to zero after the last index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_cnt       <= '0;
         fft_start    <= 1'b0;
         fft_we       <= 1'b0;
         to_fft       <= 12'd0;
         sample_index <= '0;
         active_mode  <= RECORD;
         overrun      <= 1'b0;
         drop_count   <= 8'd0;
      end else begin
         fft_start <= 1'b0;
         fft_we    <= 1'b0;
         overrun   <= sample_drop;
         if (sample_drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
         case (state)
            IDLE: begin
               if ((mode_req == RECORD) || (mode_req == PLAYBACK)) begin
                  active_mode <= mode_req;
               end
               wr_cnt    <= '0;
               fft_start <= 1'b1;
               state     <= START;
            end
            START: begin
               if (fft_rfd) begin
                  state <= FILL;
               end
            end
            FILL: begin
               if (sample_write) begin
                  to_fft       <= (active_mode == PLAYBACK) ? from_fir : from_ac97;
                  sample_index <= wr_cnt;
                  fft_we       <= 1'b1;
                  wr_cnt       <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_INDEX) begin
                     state <= WAIT_DONE;
                  end
               end
            end
            WAIT_DONE: begin
               if (fft_done || wd_expire) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
//
// Self-checking bench for fft_frame_sequencer with LOG_N = 3 (8-sample
// frames) and TIMEOUT_CYCLES = 20. Every strobe pushes its expected result
// onto a scoreboard queue, which is popped and compared one cycle later.
// Honours FFT_WATCHDOG_EN when checking the WAIT_DONE timeout behaviour.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

   localparam int LOG_N = 3;
   localparam int N     = 8;
   localparam int TO    = 20;

   logic        clock;
   logic        reset;
   logic        ready;
   logic [11:0] from_fir;
   logic [11:0] from_ac97;
   logic [1:0]  mode_req;
   logic        fft_rfd;
   logic        fft_done;
   logic        fft_start;
   logic        fft_we;
   logic [11:0] to_fft;
   logic [2:0]  sample_index;
   logic [1:0]  active_mode;
   logic        overrun;
   logic [7:0]  drop_count;
   logic        timeout;

   typedef struct {
      logic [1:0]  mode;
      logic [11:0] ac97;
      logic [11:0] fir;
      logic        rfd;
      logic        write;
      logic [11:0] data;
   } vec_t;

   typedef struct {
      logic        write;
      logic [11:0] data;
      logic [2:0]  idx;
      logic [7:0]  drops;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[11];
   int          checks;
   int          failures;
   int          exp_idx;
   int          exp_drops;
   logic [11:0] last_data;
   logic [2:0]  last_idx;

   fft_frame_sequencer #(
      .LOG_N(LOG_N),
      .PLAYBACK(2'd1),
      .RECORD(2'd0),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .ready(ready),
      .from_fir(from_fir),
      .from_ac97(from_ac97),
      .mode_req(mode_req),
      .fft_rfd(fft_rfd),
      .fft_done(fft_done),
      .fft_start(fft_start),
      .fft_we(fft_we),
      .to_fft(to_fft),
      .sample_index(sample_index),
      .active_mode(active_mode),
      .overrun(overrun),
      .drop_count(drop_count),
      .timeout(timeout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case anything stalls beyond the expected run length.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "[TB] time limit exceeded");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic check_reset_values();
      check_output("rst_fft_start", fft_start, 0);
      check_output("rst_fft_we", fft_we, 0);
      check_output("rst_overrun", overrun, 0);
      check_output("rst_timeout", timeout, 0);
      check_output("rst_to_fft", to_fft, 0);
      check_output("rst_sample_index", sample_index, 0);
      check_output("rst_active_mode", active_mode, 0);
      check_output("rst_drop_count", drop_count, 0);
   endtask

   // Drives one ready strobe (caller is at a negedge), records the expected
   // outcome on the scoreboard, then checks the registered result and that
   // the pulses drop again on the following cycle.
   task automatic apply_stimulus(input logic [11:0] ac97, input logic [11:0] fir,
                                 input logic rfd, input logic write, input logic [11:0] data);
      exp_t e;
      from_ac97 = ac97;
      from_fir  = fir;
      fft_rfd   = rfd;
      ready     = 1'b1;
      e.write   = write;
      if (write) begin
         e.data    = data;
         e.idx     = 3'(exp_idx);
         exp_idx   = (exp_idx + 1) % N;
         last_data = data;
         last_idx  = e.idx;
      end else begin
         e.data = last_data;
         e.idx  = last_idx;
         if (exp_drops < 255) exp_drops++;
      end
      e.drops = 8'(exp_drops);
      sb.push_back(e);
      @(negedge clock);
      ready   = 1'b0;
      fft_rfd = 1'b1;
      e = sb.pop_front();
      check_output("fft_we", fft_we, e.write);
      check_output("overrun", overrun, !e.write);
      check_output("to_fft", to_fft, e.data);
      check_output("sample_index", sample_index, e.idx);
      check_output("drop_count", drop_count, e.drops);
      @(negedge clock);
      check_output("fft_we_width", fft_we, 0);
      check_output("overrun_width", overrun, 0);
   endtask

   // Waits a bounded number of cycles for fft_start, then checks it is a
   // single-cycle pulse. With fft_rfd high the DUT is in FILL on return.
   task automatic wait_start(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (fft_start) begin
            seen = 1'b1;
            break;
         end
      end
      check_output("fft_start_seen", seen, 1);
      @(negedge clock);
      check_output("fft_start_width", fft_start, 0);
   endtask

   initial begin
      int to_cyc;
      int st_cyc;
      checks    = 0;
      failures  = 0;
      exp_idx   = 0;
      exp_drops = 0;
      last_data = 12'd0;
      last_idx  = 3'd0;
      reset     = 1'b1;
      ready     = 1'b0;
      from_fir  = 12'd0;
      from_ac97 = 12'd0;
      mode_req  = 2'd0;
      fft_rfd   = 1'b1;
      fft_done  = 1'b0;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check_reset_values();
      reset = 1'b0;
      wait_start(5);
      check_output("frame1_mode", active_mode, 0);

      // Frame 1: record mode, three drops mid-fill, mode request changed late
      tbl[0]  = '{2'd0, 12'h001, 12'h7FF, 1'b1, 1'b1, 12'h001};
      tbl[1]  = '{2'd0, 12'h002, 12'h7FF, 1'b1, 1'b1, 12'h002};
      tbl[2]  = '{2'd0, 12'h003, 12'h7FF, 1'b1, 1'b1, 12'h003};
      tbl[3]  = '{2'd0, 12'h004, 12'h7FF, 1'b1, 1'b1, 12'h004};
      tbl[4]  = '{2'd0, 12'h005, 12'h7FF, 1'b1, 1'b1, 12'h005};
      tbl[5]  = '{2'd0, 12'h0E1, 12'h7FF, 1'b0, 1'b0, 12'h000};
      tbl[6]  = '{2'd0, 12'h0E2, 12'h7FF, 1'b0, 1'b0, 12'h000};
      tbl[7]  = '{2'd0, 12'h0E3, 12'h7FF, 1'b0, 1'b0, 12'h000};
      tbl[8]  = '{2'd1, 12'h006, 12'h7FF, 1'b1, 1'b1, 12'h006};
      tbl[9]  = '{2'd1, 12'h007, 12'h7FF, 1'b1, 1'b1, 12'h007};
      tbl[10] = '{2'd1, 12'h008, 12'h7FF, 1'b1, 1'b1, 12'h008};
      for (int i = 0; i < 11; i++) begin
         mode_req = tbl[i].mode;
         apply_stimulus(tbl[i].ac97, tbl[i].fir, tbl[i].rfd, tbl[i].write, tbl[i].data);
      end
      check_output("frame1_mode_held", active_mode, 0);

      // WAIT_DONE: 300 strobes all dropped, counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(12'(i), 12'h7FF, 1'b1, 1'b0, 12'h000);
      end
      check_output("drop_saturated", drop_count, 255);

      // Same-cycle ready and fft_done: sample dropped, still back to IDLE
      ready    = 1'b1;
      fft_done = 1'b1;
      @(negedge clock);
      ready    = 1'b0;
      fft_done = 1'b0;
      check_output("done_overrun", overrun, 1);
      check_output("done_drop_hold", drop_count, 255);
      check_output("done_no_start_yet", fft_start, 0);
      @(negedge clock);
      check_output("frame2_start", fft_start, 1);
      check_output("frame2_mode", active_mode, 1);
      @(negedge clock);
      check_output("frame2_start_width", fft_start, 0);

      // Frame 2: playback samples from the FIR path, incl. most negative value
      for (int i = 0; i < N; i++) begin
         logic [11:0] fir_val;
         fir_val = (i == N - 1) ? 12'h800 : 12'h7FF;
         apply_stimulus(12'h100 + 12'(i), fir_val, 1'b1, 1'b1, fir_val);
      end

      // WAIT_DONE with no fft_done: watchdog behaviour
      to_cyc = 0;
      st_cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (timeout && (to_cyc == 0)) to_cyc = i + 1;
         if (fft_start && (st_cyc == 0)) st_cyc = i + 1;
      end
`ifdef FFT_WATCHDOG_EN
      check_output("timeout_cycle", to_cyc, TO);
      check_output("timeout_restart", st_cyc, TO + 1);
`else
      check_output("no_timeout", to_cyc, 0);
      check_output("no_restart", st_cyc, 0);
      fft_done = 1'b1;
      @(negedge clock);
      fft_done = 1'b0;
      wait_start(5);
`endif

      // Frame 3: abandoned by reset after five samples
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(12'h200, 12'h0A0 + 12'(i), 1'b1, 1'b1, 12'h0A0 + 12'(i));
      end
      #2 reset = 1'b1;
      #1 check_reset_values();
      exp_idx   = 0;
      exp_drops = 0;
      last_data = 12'd0;
      last_idx  = 3'd0;
      mode_req  = 2'd0;
      @(negedge clock);
      reset = 1'b0;
      wait_start(5);
      check_output("post_reset_mode", active_mode, 0);
      apply_stimulus(12'h123, 12'h7FF, 1'b1, 1'b1, 12'h123);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
